// File: rtl/button_event_gen_if.sv
// Button-side signal bundle: raw BTNC in, conditioned events and levels out.
interface button_event_gen_if;
  logic BTNC;
  logic button_down;
  logic long_press;
  logic pressed;
  logic repeat_active;

  modport master (output BTNC, input button_down, long_press, pressed, repeat_active);
  modport slave  (input BTNC, output button_down, long_press, pressed, repeat_active);
endinterface

// File: rtl/button_event_gen.sv
// Raw push-button -> synchronized, debounced level plus press / long-press / auto-repeat pulses.
// Optional feature macro: BUTTON_AUTO_REPEAT_EN (adds the REPEAT state and its period counter).
module button_event_gen #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int HOLD_CYC     = 50_000_000,
  parameter int REPEAT_CYC   = 10_000_000
) (
  input logic          clk,
  input logic          CPU_RESETN,
  button_event_gen_if.slave btn
);

  localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int HW = $clog2(HOLD_CYC);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYC);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYC - 1);
`endif

  typedef enum logic [1:0] {
    IDLE,
    PRESSED
`ifdef BUTTON_AUTO_REPEAT_EN
    , REPEAT
`endif
  } state_t;

  logic [1:0]    sync_pipe;
  logic          sync_btn;
  logic          pressed_q;
  logic [DW-1:0] db_cnt;
  logic          db_hit, rise, fall;

  state_t        state, state_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic          bd_q, bd_n, lp_q, lp_n;
`ifdef BUTTON_AUTO_REPEAT_EN
  logic [RW-1:0] rep_cnt, rep_n;
`else
  logic          hold_done, done_n;
`endif

  assign sync_btn = sync_pipe[1];
  // Level flips on the same edge the FSM sees rise/fall, so pulses align with offset 0.
  assign db_hit   = (sync_btn != pressed_q) && (db_cnt == DB_LAST);
  assign rise     = db_hit && !pressed_q;
  assign fall     = db_hit && pressed_q;

  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sync_pipe <= '0;
      pressed_q <= 1'b0;
      db_cnt    <= '0;
    end else begin
      sync_pipe <= {sync_pipe[0], btn.BTNC};
      if (sync_btn == pressed_q) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        pressed_q <= ~pressed_q;
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state    <= IDLE;
      hold_cnt <= '0;
      bd_q     <= 1'b0;
      lp_q     <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
      rep_cnt  <= '0;
`else
      hold_done <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      hold_cnt <= hold_n;
      bd_q     <= bd_n;
      lp_q     <= lp_n;
`ifdef BUTTON_AUTO_REPEAT_EN
      rep_cnt  <= rep_n;
`else
      hold_done <= done_n;
`endif
    end
  end

  // Release has priority: a timer expiring in the falling cycle emits nothing.
  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    bd_n    = 1'b0;
    lp_n    = 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
    rep_n   = rep_cnt;
`else
    done_n  = hold_done;
`endif
    case (state)
      IDLE: begin
        if (rise) begin
          state_n = PRESSED;
          hold_n  = '0;
          bd_n    = 1'b1;
`ifndef BUTTON_AUTO_REPEAT_EN
          done_n  = 1'b0;
`endif
        end
      end
      PRESSED: begin
        if (fall) begin
          state_n = IDLE;
        end else if (hold_cnt == HOLD_LAST) begin
`ifdef BUTTON_AUTO_REPEAT_EN
          lp_n    = 1'b1;
          bd_n    = 1'b1;
          state_n = REPEAT;
          rep_n   = '0;
`else
          if (!hold_done) begin
            lp_n   = 1'b1;
            done_n = 1'b1;
          end
`endif
        end else begin
          hold_n = hold_cnt + 1'b1;
        end
      end
`ifdef BUTTON_AUTO_REPEAT_EN
      REPEAT: begin
        if (fall) begin
          state_n = IDLE;
        end else if (rep_cnt == REP_LAST) begin
          bd_n  = 1'b1;
          rep_n = '0;
        end else begin
          rep_n = rep_cnt + 1'b1;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  assign btn.button_down = bd_q;
  assign btn.long_press  = lp_q;
  assign btn.pressed     = pressed_q;
`ifdef BUTTON_AUTO_REPEAT_EN
  assign btn.repeat_active = (state == REPEAT);
`else
  assign btn.repeat_active = 1'b0;
`endif

endmodule
